// File: rtl/fft_bar_writer.sv
// Renders seven FFT bar heights into the frame buffer as 3-bit bin codes, one write per clock.
// Define FFT_BAR_GAP_EN to blank the last GAP_W pixels of every column as separators.
module fft_bar_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_W    = 91,
  parameter int GAP_W    = 4
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic [62:0] heights,
  input  logic        heights_valid,
  output logic        heights_ready,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        frame_ready
);

  localparam int NBINS = 7;
  localparam int OW    = $clog2(COL_W);
`ifdef FFT_BAR_GAP_EN
  localparam int GAP_ON = 1;
`else
  localparam int GAP_ON = 0;
`endif
  localparam logic [18:0]   LAST      = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [9:0]    XLAST     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    YV        = 10'(V_ACTIVE);
  localparam logic [8:0]    HMAX      = 9'(V_ACTIVE);
  localparam logic [OW-1:0] OLAST     = OW'(COL_W - 1);
  // With the gap disabled the start offset is COL_W, which the offset never reaches.
  localparam logic [OW-1:0] GAP_START = OW'(COL_W - GAP_W * GAP_ON);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_n;

  logic [NBINS-1:0][8:0] h_in, h_lat;
  logic [9:0]    x_cnt, y_cnt;
  logic [OW-1:0] off_cnt;
  logic [2:0]    col_idx;   // column k-1
  logic          col_none;  // past the last column (x >= 7*COL_W)
  logic [18:0]   addr_cnt;
  logic          accept, emit, clr;
  logic [8:0]    h_sel;
  logic          in_gap, lit;
  logic [2:0]    pix;

  always_comb begin
    for (int j = 0; j < NBINS; j++)
      h_in[j] = (heights[9*j +: 9] > HMAX) ? HMAX : heights[9*j +: 9];
  end

  assign accept = (state == IDLE) && heights_valid && heights_ready;

  // state register
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SWEEP;
      SWEEP:   if (addr_cnt == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // per-cycle controls
  always_comb begin
    emit = 1'b0;
    clr  = 1'b0;
    case (state)
      IDLE:    emit = accept;
      SWEEP:   emit = 1'b1;
      DONE:    clr  = 1'b1;
      default: ;
    endcase
  end

  // The first pixel is emitted on the accept edge, before the latch is visible.
  assign h_sel  = (state == IDLE) ? h_in[col_idx] : h_lat[col_idx];
  assign in_gap = (off_cnt >= GAP_START);
  assign lit    = !col_none && (({1'b0, h_sel} + y_cnt) >= YV) && !in_gap;
  assign pix    = lit ? (col_idx + 3'd1) : 3'd0;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      off_cnt  <= '0;
      col_idx  <= '0;
      col_none <= 1'b0;
      addr_cnt <= '0;
    end else if (clr) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      off_cnt  <= '0;
      col_idx  <= '0;
      col_none <= 1'b0;
      addr_cnt <= '0;
    end else if (emit) begin
      addr_cnt <= addr_cnt + 19'd1;
      if (x_cnt == XLAST) begin
        x_cnt    <= '0;
        y_cnt    <= y_cnt + 10'd1;
        off_cnt  <= '0;
        col_idx  <= '0;
        col_none <= 1'b0;
      end else begin
        x_cnt <= x_cnt + 10'd1;
        if (!col_none) begin
          if (off_cnt == OLAST) begin
            off_cnt <= '0;
            if (col_idx == 3'(NBINS - 1)) col_none <= 1'b1;
            else                          col_idx  <= col_idx + 3'd1;
          end else begin
            off_cnt <= off_cnt + OW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) h_lat <= '0;
    else if (accept) h_lat <= h_in;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_ready   <= 1'b0;
      heights_ready <= 1'b0;
    end else begin
      wr_en   <= emit;
      wr_data <= emit ? pix : 3'd0;
      if (emit) wr_addr <= addr_cnt;
      if (clr) frame_ready <= 1'b1;
      // One dead cycle after DONE before the next set is accepted.
      heights_ready <= (state_n == IDLE) && (state != DONE);
    end
  end

endmodule

// File: tb/tb_fft_bar_writer.sv
// Bench for fft_bar_writer: short frames (V_ACTIVE=16), per-write scoreboard plus spot checks.
module tb_fft_bar_writer;
  localparam int H = 640;
  localparam int V = 16;
  localparam int CW = 91;
  localparam int GW = 4;
  localparam int F = H * V;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic [62:0] heights;
  logic        heights_valid;
  logic        heights_ready;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic        frame_ready;

  fft_bar_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .COL_W(CW), .GAP_W(GW)) dut (
    .video_clk(video_clk), .rst_n(rst_n), .heights(heights),
    .heights_valid(heights_valid), .heights_ready(heights_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_ready(frame_ready)
  );

  always #5 video_clk = ~video_clk;

  typedef struct {
    logic [62:0] h;
    logic [62:0] hm;
    bit          mid;
    int          sa[4];
    logic [2:0]  sd[4];
  } vec_t;

  typedef struct {
    int         addr;
    logic [2:0] data;
  } exp_t;

  vec_t tbl[4];
  vec_t cur;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit fr_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_code(input int x, input int y, input logic [62:0] h);
    int k, off, hv;
    if (x >= 7 * CW) return 3'd0;
    k = x / CW;
    off = x % CW;
`ifdef FFT_BAR_GAP_EN
    if (off >= CW - GW) return 3'd0;
`endif
    hv = int'(h[9*k +: 9]);
    if (hv > V) hv = V;
    return (y + hv >= V) ? 3'(k + 1) : 3'd0;
  endfunction

  // scoreboard consumer
  always @(negedge video_clk) begin
    if (rst_n && wr_en) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(wr_addr), 32'hffff_ffff);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("rdy_busy", 32'(heights_ready), 0);
        for (int i = 0; i < 4; i++)
          if (e.addr == cur.sa[i]) chk("spot", 32'(wr_data), 32'(cur.sd[i]));
      end
    end
  end

  task automatic start_frame(input vec_t v);
    int n;
    n = 0;
    while (!heights_ready && n < 50) begin
      @(negedge video_clk);
      n++;
    end
    chk("ready_wait", 32'(heights_ready), 1);
    cur = v;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        exp_t e;
        e.addr = y * H + x;
        e.data = exp_code(x, y, v.h);
        q.push_back(e);
      end
    heights = v.h;
    heights_valid = 1'b1;
    @(posedge video_clk);
    #1 heights_valid = 1'b0;
    @(negedge video_clk);
    chk("first_wr_en", 32'(wr_en), 1);
    chk("first_addr", 32'(wr_addr), 0);
  endtask

  task automatic run_frame(input vec_t v);
    start_frame(v);
    for (int c = 2; c <= F; c++) begin
      @(negedge video_clk);
      if (v.mid && c == 100) begin
        heights = v.hm;
        heights_valid = 1'b1;
      end
      if (v.mid && c == 104) begin
        chk("rdy_mid", 32'(heights_ready), 0);
        heights_valid = 1'b0;
        heights = v.h;
      end
    end
    chk("last_wr_en", 32'(wr_en), 1);
    chk("last_addr", 32'(wr_addr), F - 1);
    chk("fr_at_last", 32'(frame_ready), 32'(fr_exp));
    @(negedge video_clk);
    chk("done_wr_en", 32'(wr_en), 0);
    chk("done_fr", 32'(frame_ready), 1);
    chk("done_rdy", 32'(heights_ready), 0);
    fr_exp = 1'b1;
    @(negedge video_clk);
    chk("rdy_back", 32'(heights_ready), 1);
    chk("q_left", 32'(q.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    heights = '0;
    heights_valid = 1'b0;

    tbl[0] = '{h: 63'd0, hm: {7{9'd16}}, mid: 1'b1,
               sa: '{0, 5000, F - 1, 637}, sd: '{3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[1] = '{h: {9'd1, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd16}, hm: 63'd0, mid: 1'b0,
               sa: '{86, 91, 10146, 10237}, sd: '{3'd1, 3'd0, 3'd7, 3'd0}};
    tbl[2] = '{h: {9'd0, 9'd0, 9'd0, 9'd0, 9'd511, 9'd0, 9'd0}, hm: 63'd0, mid: 1'b1,
               sa: '{182, 260, 273, 9781}, sd: '{3'd3, 3'd3, 3'd0, 3'd0}};
    tbl[3] = '{h: {9'd8, 9'd2, 9'd300, 9'd16, 9'd0, 9'd10, 9'd5}, hm: 63'd0, mid: 1'b0,
               sa: '{7040, 6400, 3931, 364}, sd: '{3'd1, 3'd0, 3'd2, 3'd5}};

    repeat (3) @(negedge video_clk);
    chk("rst_rdy", 32'(heights_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_fr", 32'(frame_ready), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge video_clk);
    chk("idle_rdy", 32'(heights_ready), 1);
    chk("idle_wr_en", 32'(wr_en), 0);
    chk("idle_fr", 32'(frame_ready), 0);
    chk("idle_addr", 32'(wr_addr), 0);

    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // reset in the middle of a sweep
    start_frame(tbl[3]);
    repeat (999) @(negedge video_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_fr", 32'(frame_ready), 0);
    chk("mid_rst_rdy", 32'(heights_ready), 0);
    chk("mid_rst_addr", 32'(wr_addr), 0);
    q.delete();
    fr_exp = 1'b0;
    repeat (3) @(negedge video_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge video_clk);
    run_frame(tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
